// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg
// Shared constants for the fetch sequencer: reset/handler vectors, the
// FETCH/ISSUE state encodings and a word-alignment helper.
package pc_sequencer_pkg;

  localparam logic [31:0] INITIAL_ADDRESS = 32'h0000_3000;
  localparam logic [31:0] HANDLER_ADDRESS = 32'h0000_4180;

  localparam logic [0:0] SEQ_FETCH = 1'b0;
  localparam logic [0:0] SEQ_ISSUE = 1'b1;

  // Redirect targets are word addresses; the two low bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_sequencer_pc_reg.sv
// pc_reg
// 32-bit program-counter register with synchronous active-high reset to
// INIT_ADDR and a write enable.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   i_we       : load i_d on the next rising edge
//   i_d        : next PC value
//   o_q        : current PC value
module pc_reg
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] INIT_ADDR = INITIAL_ADDRESS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_we,
  input  logic [31:0] i_d,
  output logic [31:0] o_q
);

  logic [31:0] r_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= INIT_ADDR;
    end else if (i_we) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Fetch sequencer: owns the PC and the instruction-memory request handshake
// and selects the next PC (sequential, branch, jump and, optionally,
// exception entry/return). One instruction takes FETCH (request until ack)
// followed by ISSUE (instruction valid until not stalled, then retire).
//
// Optional feature macro: PC_SEQUENCER_EXC_EN adds exc_req, eret and epc.
//
// Handshake: in FETCH imem_req is high and the state advances on the first
// cycle imem_ack is high; imem_ack outside FETCH is ignored. In ISSUE
// instr_valid is high and the instruction retires on the first cycle stall
// is low; redirect inputs are sampled only on that retiring cycle.
//
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   stall                   : hold the issuing instruction
//   br_taken, br_target     : taken conditional branch and its destination
//   jmp, jmp_target         : unconditional jump and its destination
//   exc_req, eret           : exception entry / return (PC_SEQUENCER_EXC_EN)
//   imem_req, imem_addr     : fetch request and address (address == pc)
//   imem_ack                : instruction returned this cycle
//   instr_valid             : fetched instruction is issuing
//   pc                      : current PC
//   epc                     : saved exception PC (PC_SEQUENCER_EXC_EN)
//   icount                  : retired-instruction counter
//   dbg_state               : current FSM state (SEQ_FETCH / SEQ_ISSUE)
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] INIT_ADDR    = INITIAL_ADDRESS,
  parameter logic [31:0] HANDLER_ADDR = HANDLER_ADDRESS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp,
  input  logic [31:0] jmp_target,
`ifdef PC_SEQUENCER_EXC_EN
  input  logic        exc_req,
  input  logic        eret,
  output logic [31:0] epc,
`endif
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] icount,
  output logic [0:0]  dbg_state
);

  logic [0:0]  r_state;
  logic [31:0] r_icount;
  logic [31:0] w_pc;
  logic [31:0] w_next_pc;
  logic        w_retire;

  assign w_retire = (r_state == SEQ_ISSUE) && !stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= SEQ_FETCH;
    end else begin
      case (r_state)
        SEQ_FETCH: if (imem_ack) r_state <= SEQ_ISSUE;
        SEQ_ISSUE: if (!stall)   r_state <= SEQ_FETCH;
        default:                 r_state <= SEQ_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_icount <= 32'd0;
    end else if (w_retire) begin
      r_icount <= r_icount + 32'd1;
    end
  end

`ifdef PC_SEQUENCER_EXC_EN
  logic [31:0] r_epc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_epc <= 32'd0;
    end else if (w_retire && exc_req) begin
      r_epc <= w_pc;
    end
  end

  always_comb begin
    w_next_pc = w_pc + 32'd4;
    if (exc_req)       w_next_pc = word_align(HANDLER_ADDR);
    else if (eret)     w_next_pc = word_align(r_epc);
    else if (jmp)      w_next_pc = word_align(jmp_target);
    else if (br_taken) w_next_pc = word_align(br_target);
  end

  assign epc = r_epc;
`else
  // HANDLER_ADDR has no role without exception support.
  logic w_unused_handler;
  assign w_unused_handler = ^HANDLER_ADDR;

  always_comb begin
    w_next_pc = w_pc + 32'd4;
    if (jmp)           w_next_pc = word_align(jmp_target);
    else if (br_taken) w_next_pc = word_align(br_target);
  end
`endif

  pc_reg #(
    .INIT_ADDR (INIT_ADDR)
  ) u_pc_reg (
    .clk   (clk),
    .reset (reset),
    .i_we  (w_retire),
    .i_d   (w_next_pc),
    .o_q   (w_pc)
  );

  assign imem_req    = (r_state == SEQ_FETCH);
  assign instr_valid = (r_state == SEQ_ISSUE);
  assign imem_addr   = w_pc;
  assign pc          = w_pc;
  assign icount      = r_icount;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
// Self-checking bench for pc_sequencer. Inputs are driven on the falling
// edge and outputs are observed on the falling edge, half a cycle away from
// the active rising edge. The reference model works per instruction: it
// tracks pc/epc/icount and applies the redirect priority when an
// instruction retires.
module tb_pc_sequencer;

  localparam logic [31:0] INIT_PC    = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
`ifdef PC_SEQUENCER_EXC_EN
  localparam bit EXC_EN = 1'b1;
`else
  localparam bit EXC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jmp;
  logic [31:0] jmp_target;
  logic        exc_req;
  logic        eret;
  logic [31:0] epc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] icount;
  logic [0:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [31:0] m_pc;
  logic [31:0] m_epc;
  logic [31:0] m_icount;

  pc_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .jmp         (jmp),
    .jmp_target  (jmp_target),
`ifdef PC_SEQUENCER_EXC_EN
    .exc_req     (exc_req),
    .eret        (eret),
    .epc         (epc),
`endif
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .instr_valid (instr_valid),
    .pc          (pc),
    .icount      (icount),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_inputs();
    stall      = 1'b0;
    br_taken   = 1'b0;
    br_target  = 32'd0;
    jmp        = 1'b0;
    jmp_target = 32'd0;
    exc_req    = 1'b0;
    eret       = 1'b0;
    imem_ack   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_pc     = INIT_PC;
    m_epc    = 32'd0;
    m_icount = 32'd0;
  endtask

  // ---------------- reference model ----------------
  task automatic model_retire(input logic j, input logic [31:0] jt,
                              input logic b, input logic [31:0] bt,
                              input logic e, input logic r);
    if (EXC_EN && e) begin
      m_epc = m_pc;
      m_pc  = HANDLER_PC;
    end else if (EXC_EN && r) begin
      m_pc = m_epc;
    end else if (j) begin
      m_pc = jt & 32'hFFFF_FFFC;
    end else if (b) begin
      m_pc = bt & 32'hFFFF_FFFC;
    end else begin
      m_pc = m_pc + 32'd4;
    end
    m_icount = m_icount + 32'd1;
  endtask

  // ---------------- driver: one full instruction ----------------
  // Called at a falling edge with the DUT in FETCH; returns at the falling
  // edge after retirement (DUT back in FETCH).
  task automatic run_instr(input int waits, input int stalls,
                           input logic j, input logic [31:0] jt,
                           input logic b, input logic [31:0] bt,
                           input logic e, input logic r);
    for (int i = 0; i < waits; i++) begin
      checks++;
      if (imem_req !== 1'b1 || instr_valid !== 1'b0) begin
        errors++;
        $display("FAIL fetch_wait: req=%0b valid=%0b, need req=1 valid=0", imem_req, instr_valid);
      end
      checks++;
      if (pc !== m_pc || imem_addr !== m_pc) begin
        errors++;
        $display("FAIL fetch_wait_pc: pc=%h addr=%h, need %h", pc, imem_addr, m_pc);
      end
      // Redirects outside a retiring cycle must have no effect.
      imem_ack   = 1'b0;
      jmp        = 1'($urandom_range(0, 1));
      br_taken   = 1'($urandom_range(0, 1));
      jmp_target = $urandom;
      br_target  = $urandom;
      exc_req    = 1'($urandom_range(0, 1));
      eret       = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    checks++;
    if (imem_req !== 1'b1 || instr_valid !== 1'b0 || pc !== m_pc) begin
      errors++;
      $display("FAIL fetch_ack: req=%0b valid=%0b pc=%h, need req=1 valid=0 pc=%h",
               imem_req, instr_valid, pc, m_pc);
    end
    imem_ack = 1'b1;
    @(negedge clk);
    for (int i = 0; i < stalls; i++) begin
      checks++;
      if (instr_valid !== 1'b1 || imem_req !== 1'b0 || pc !== m_pc) begin
        errors++;
        $display("FAIL issue_stall: valid=%0b req=%0b pc=%h, need valid=1 req=0 pc=%h",
                 instr_valid, imem_req, pc, m_pc);
      end
      stall      = 1'b1;
      jmp        = j;
      jmp_target = jt;
      br_taken   = b;
      br_target  = bt;
      exc_req    = e;
      eret       = r;
      imem_ack   = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    checks++;
    if (instr_valid !== 1'b1 || imem_req !== 1'b0 || pc !== m_pc) begin
      errors++;
      $display("FAIL issue: valid=%0b req=%0b pc=%h, need valid=1 req=0 pc=%h",
               instr_valid, imem_req, pc, m_pc);
    end
    stall      = 1'b0;
    jmp        = j;
    jmp_target = jt;
    br_taken   = b;
    br_target  = bt;
    exc_req    = e;
    eret       = r;
    imem_ack   = 1'($urandom_range(0, 1));
    @(negedge clk);
    clear_inputs();
    model_retire(j, jt, b, bt, e, r);
    checks++;
    if (pc !== m_pc || imem_addr !== m_pc || imem_req !== 1'b1 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL retire: pc=%h addr=%h req=%0b valid=%0b, need pc=%h req=1 valid=0",
               pc, imem_addr, imem_req, instr_valid, m_pc);
    end
    checks++;
    if (icount !== m_icount) begin
      errors++;
      $display("FAIL icount: got %0d, need %0d", icount, m_icount);
    end
`ifdef PC_SEQUENCER_EXC_EN
    checks++;
    if (epc !== m_epc) begin
      errors++;
      $display("FAIL epc: got %h, need %h", epc, m_epc);
    end
`endif
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    checks++;
    if (pc !== 32'h0000_3000 || imem_addr !== 32'h0000_3000) begin
      errors++;
      $display("FAIL reset_pc: pc=%h addr=%h, need 00003000", pc, imem_addr);
    end
    checks++;
    if (imem_req !== 1'b1 || instr_valid !== 1'b0 || dbg_state !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: req=%0b valid=%0b state=%0b, need 1 0 0",
               imem_req, instr_valid, dbg_state);
    end
    checks++;
    if (icount !== 32'd0) begin
      errors++;
      $display("FAIL reset_icount: got %0d, need 0", icount);
    end
`ifdef PC_SEQUENCER_EXC_EN
    checks++;
    if (epc !== 32'd0) begin
      errors++;
      $display("FAIL reset_epc: got %h, need 0", epc);
    end
`endif
  endtask

  task automatic test_sequential();
    do_reset();
    run_instr(0, 0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    checks++;
    if (pc !== 32'h0000_3004) begin
      errors++;
      $display("FAIL seq_pc1: got %h, need 00003004", pc);
    end
    run_instr(0, 0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    checks++;
    if (pc !== 32'h0000_3008) begin
      errors++;
      $display("FAIL seq_pc2: got %h, need 00003008", pc);
    end
    run_instr(0, 0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    checks++;
    if (icount !== 32'd3) begin
      errors++;
      $display("FAIL seq_icount: got %0d, need 3", icount);
    end
  endtask

  task automatic test_wait_states();
    do_reset();
    run_instr(2, 0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    checks++;
    if (pc !== 32'h0000_3004 || icount !== 32'd1) begin
      errors++;
      $display("FAIL wait_retire: pc=%h icount=%0d, need 00003004 1", pc, icount);
    end
  endtask

  task automatic test_stall_branch();
    do_reset();
    run_instr(0, 4, 1'b0, 32'd0, 1'b1, 32'h0000_3100, 1'b0, 1'b0);
    checks++;
    if (pc !== 32'h0000_3100) begin
      errors++;
      $display("FAIL stall_branch: got %h, need 00003100", pc);
    end
  endtask

  task automatic test_jmp_priority();
    do_reset();
    run_instr(1, 1, 1'b1, 32'h0000_3203, 1'b1, 32'h0000_3300, 1'b0, 1'b0);
    checks++;
    if (pc !== 32'h0000_3200) begin
      errors++;
      $display("FAIL jmp_priority: got %h, need 00003200", pc);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    run_instr(0, 0, 1'b1, 32'hFFFF_FFFE, 1'b0, 32'd0, 1'b0, 1'b0);
    checks++;
    if (pc !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_jmp: got %h, need fffffffc", pc);
    end
    run_instr(0, 0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    checks++;
    if (pc !== 32'h0000_0000) begin
      errors++;
      $display("FAIL wrap_seq: got %h, need 00000000", pc);
    end
  endtask

`ifdef PC_SEQUENCER_EXC_EN
  task automatic test_exception();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      run_instr(0, 0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    end
    run_instr(0, 2, 1'b1, 32'h0000_5000, 1'b1, 32'h0000_6000, 1'b1, 1'b1);
    checks++;
    if (pc !== 32'h0000_4180 || epc !== 32'h0000_3010) begin
      errors++;
      $display("FAIL exc_entry: pc=%h epc=%h, need 00004180 00003010", pc, epc);
    end
    run_instr(1, 0, 1'b1, 32'h0000_5000, 1'b0, 32'd0, 1'b0, 1'b1);
    checks++;
    if (pc !== 32'h0000_3010) begin
      errors++;
      $display("FAIL exc_return: got %h, need 00003010", pc);
    end
  endtask
`endif

  task automatic test_reset_mid_wait();
    do_reset();
    run_instr(0, 0, 1'b0, 32'd0, 1'b1, 32'h0000_3400, 1'b0, 1'b0);
    run_instr(1, 0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    imem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    // Reset in a wait state while an ack arrives together with it.
    reset    = 1'b1;
    imem_ack = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    imem_ack = 1'b0;
    m_pc     = INIT_PC;
    m_epc    = 32'd0;
    m_icount = 32'd0;
    checks++;
    if (pc !== 32'h0000_3000 || imem_req !== 1'b1 || instr_valid !== 1'b0 || icount !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_wait: pc=%h req=%0b valid=%0b icount=%0d, need 00003000 1 0 0",
               pc, imem_req, instr_valid, icount);
    end
    // Reset during a stall.
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    stall    = 1'b1;
    jmp      = 1'b1;
    jmp_target = 32'h0000_7000;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    clear_inputs();
    reset = 1'b0;
    checks++;
    if (pc !== 32'h0000_3000 || imem_req !== 1'b1 || instr_valid !== 1'b0 || icount !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_stall: pc=%h req=%0b valid=%0b icount=%0d, need 00003000 1 0 0",
               pc, imem_req, instr_valid, icount);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 60; n++) begin
      logic j, b, e, r;
      j = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 2) == 0);
      e = EXC_EN && ($urandom_range(0, 9) == 0);
      r = EXC_EN && ($urandom_range(0, 7) == 0);
      run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                j, $urandom, b, $urandom, e, r);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_sequential();
    test_wait_states();
    test_stall_branch();
    test_jmp_priority();
    test_wrap();
`ifdef PC_SEQUENCER_EXC_EN
    test_exception();
`endif
    test_reset_mid_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
